// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous memory.
// One access in flight at a time; each access completes with a one-cycle ack and registered read data.
module mem_arbiter #(
    parameter int AW       = 20,
    parameter int DW       = 8,
    parameter int READ_LAT = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_out,
    output logic [DW-1:0] m0_in,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_out,
    output logic [DW-1:0] m1_in,
    output logic          m1_ack,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_out,
    output logic          mem_we,
    input  logic [DW-1:0] mem_in,
    output logic [1:0]    grant
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_t     state;
    logic [2:0] cnt;
    logic       last;
    logic       elig0;
    logic       elig1;
    logic       pick1;

    // A master whose ack is high this cycle is not eligible, so a stale req cannot re-issue.
    assign elig0 = m0_req & ~m0_ack;
    assign elig1 = m1_req & ~m1_ack;
    assign pick1 = elig1 & (~elig0 | ~last);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= 2'b00;
            mem_address <= '0;
            mem_out     <= '0;
            mem_we      <= 1'b0;
            m0_in       <= '0;
            m1_in       <= '0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            cnt         <= 3'd0;
            last        <= 1'b1;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        grant       <= pick1 ? 2'b10 : 2'b01;
                        last        <= pick1;
                        mem_address <= pick1 ? m1_address : m0_address;
                        mem_out     <= pick1 ? m1_out : m0_out;
                        mem_we      <= pick1 ? m1_we : m0_we;
                        cnt         <= 3'd1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (cnt < LAT) begin
                        cnt <= cnt + 3'd1;
                    end else begin
                        // Data is returned for writes too; masters ignore it.
                        if (grant[1]) begin
                            m1_in  <= mem_in;
                            m1_ack <= 1'b1;
                        end else begin
                            m0_in  <= mem_in;
                            m0_ack <= 1'b1;
                        end
                        grant <= 2'b00;
                        cnt   <= 3'd0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected acks plus a READ_LAT=5 instance.
module tb_mem_arbiter;

    localparam int AW  = 20;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_address, m1_address;
    logic [DW-1:0] m0_out, m1_out;
    logic [DW-1:0] m0_in, m1_in;
    logic          m0_ack, m1_ack;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_out;
    logic          mem_we;
    logic [DW-1:0] mem_in;
    logic [1:0]    grant;

    logic          l5_m0_req, l5_m0_we, l5_m1_req, l5_m1_we;
    logic [AW-1:0] l5_m0_address, l5_m1_address;
    logic [DW-1:0] l5_m0_out, l5_m1_out;
    logic [DW-1:0] l5_m0_in, l5_m1_in;
    logic          l5_m0_ack, l5_m1_ack;
    logic [AW-1:0] l5_mem_address;
    logic [DW-1:0] l5_mem_out;
    logic          l5_mem_we;
    logic [DW-1:0] l5_mem_in;
    logic [1:0]    l5_grant;

    mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_address(m0_address), .m0_out(m0_out),
        .m0_in(m0_in), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_address(m1_address), .m1_out(m1_out),
        .m1_in(m1_in), .m1_ack(m1_ack),
        .mem_address(mem_address), .mem_out(mem_out), .mem_we(mem_we),
        .mem_in(mem_in), .grant(grant)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(5)) dut5 (
        .clock(clock), .reset_n(reset_n),
        .m0_req(l5_m0_req), .m0_we(l5_m0_we), .m0_address(l5_m0_address), .m0_out(l5_m0_out),
        .m0_in(l5_m0_in), .m0_ack(l5_m0_ack),
        .m1_req(l5_m1_req), .m1_we(l5_m1_we), .m1_address(l5_m1_address), .m1_out(l5_m1_out),
        .m1_in(l5_m1_in), .m1_ack(l5_m1_ack),
        .mem_address(l5_mem_address), .mem_out(l5_mem_out), .mem_we(l5_mem_we),
        .mem_in(l5_mem_in), .grant(l5_grant)
    );

    // Memory model: unwritten locations read as (addr[7:0] ^ 0x4A); writes land on the strobe edge.
    bit       written [256];
    bit [7:0] wdata   [256];

    always @(posedge clock) begin
        if (mem_we === 1'b1) begin
            written[mem_address[7:0]] <= 1'b1;
            wdata[mem_address[7:0]]   <= mem_out;
        end
    end

    always_comb begin
        mem_in    = written[mem_address[7:0]] ? wdata[mem_address[7:0]] : (mem_address[7:0] ^ 8'h4A);
        l5_mem_in = l5_mem_address[7:0] ^ 8'h4A;
    end

    function automatic logic [7:0] model_rd(input logic [AW-1:0] a);
        return written[a[7:0]] ? wdata[a[7:0]] : (a[7:0] ^ 8'h4A);
    endfunction

    typedef struct {
        int         m;
        logic       we;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int m, input logic we, input logic [AW-1:0] a);
        exp_t e;
        e.m    = m;
        e.we   = we;
        e.data = model_rd(a);
        q.push_back(e);
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clock) begin
        if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
            chk("single_ack", {31'b0, m0_ack & m1_ack}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_ack: observed m0_ack=%0b m1_ack=%0b required no ack", m0_ack, m1_ack);
            end else begin
                mon_e = q.pop_front();
                chk("ack_master", {31'b0, m1_ack}, mon_e.m);
                if (!mon_e.we)
                    chk("read_data", (mon_e.m == 1) ? m1_in : m0_in, mon_e.data);
                $display("txn: m%0d %s ack, data 0x%02h", mon_e.m, mon_e.we ? "write" : "read",
                         (mon_e.m == 1) ? m1_in : m0_in);
            end
        end
    end

    task automatic do_access(input int m, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        int         n;
        bit         got;
        logic [1:0] g;
        @(negedge clock);
        if (m == 0) begin
            m0_req = 1'b1; m0_we = we; m0_address = a; m0_out = d;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_address = a; m1_out = d;
        end
        push_exp(m, we, a);
        g   = (m == 0) ? 2'b01 : 2'b10;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                chk("grant_e0", grant, g);
                chk("mem_we_e0", mem_we, we);
                chk("mem_address_e0", mem_address, a);
                if (we) chk("mem_out_e0", mem_out, d);
            end else if (n <= LAT) begin
                chk("mem_we_low", mem_we, 1'b0);
                chk("grant_hold", grant, g);
                chk("address_hold", mem_address, a);
            end
            chk("other_ack_low", (m == 0) ? m1_ack : m0_ack, 1'b0);
            if ((m == 0 && m0_ack === 1'b1) || (m == 1 && m1_ack === 1'b1)) begin
                got = 1'b1;
                chk("grant_idle_at_ack", grant, 2'b00);
            end
        end
        chk("ack_latency", n, LAT + 1);
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        int n;
        int acks;
        int prev;
        reset_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_address = '0; m0_out = '0;
        m1_req = 0; m1_we = 0; m1_address = '0; m1_out = '0;
        l5_m0_req = 0; l5_m0_we = 0; l5_m0_address = '0; l5_m0_out = '0;
        l5_m1_req = 0; l5_m1_we = 0; l5_m1_address = '0; l5_m1_out = '0;

        repeat (3) @(negedge clock);
        chk("rst_grant", grant, 2'b00);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_mem_out", mem_out, '0);
        chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
        chk("rst_rdata", {m0_in, m1_in}, 16'h0000);
        reset_n = 1'b1;

        do_access(0, 1'b0, 20'h00010, 8'h00);
        chk("m0_in_5a", m0_in, 8'h5A);
        do_access(1, 1'b1, 20'hA0123, 8'h3C);
        do_access(0, 1'b0, 20'hA0123, 8'h00);

        // Stale req held past ack: no regrant at the edge where ack is high.
        @(negedge clock);
        m0_req = 1'b1; m0_we = 1'b0; m0_address = 20'h00077;
        push_exp(0, 1'b0, 20'h00077);
        push_exp(0, 1'b0, 20'h00077);
        n = 0;
        do begin @(negedge clock); n++; end while (m0_ack !== 1'b1 && n < 20);
        chk("stale_first_lat", n, LAT + 1);
        @(negedge clock);
        chk("stale_no_regrant", grant, 2'b00);
        chk("stale_ack_cleared", m0_ack, 1'b0);
        @(negedge clock);
        chk("stale_regrant", grant, 2'b01);
        n = 0;
        do begin @(negedge clock); n++; end while (m0_ack !== 1'b1 && n < 20);
        chk("stale_second_lat", n, LAT);
        m0_req = 1'b0;

        // Reset in the middle of a write abandons it without an ack.
        @(negedge clock);
        m0_req = 1'b1; m0_we = 1'b1; m0_address = 20'h00040; m0_out = 8'h77;
        @(negedge clock);
        chk("abort_we_high", mem_we, 1'b1);
        #1 reset_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0;
        #1;
        chk("abort_we_async", mem_we, 1'b0);
        chk("abort_grant", grant, 2'b00);
        repeat (3) begin
            @(negedge clock);
            chk("abort_no_ack", m0_ack, 1'b0);
        end
        reset_n = 1'b1;

        // Tie from reset: m0 first, then strict alternation every LAT+1 cycles.
        m0_req = 1'b1; m0_we = 1'b0; m0_address = 20'h00020;
        m1_req = 1'b1; m1_we = 1'b0; m1_address = 20'h00031;
        push_exp(0, 1'b0, 20'h00020);
        push_exp(1, 1'b0, 20'h00031);
        push_exp(0, 1'b0, 20'h00020);
        push_exp(1, 1'b0, 20'h00031);
        n = 0; acks = 0; prev = 0;
        while (acks < 4 && n < 40) begin
            @(negedge clock);
            n++;
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                acks++;
                if (acks == 1) chk("tie_first_lat", n, LAT + 1);
                else           chk("alt_period", n - prev, LAT + 1);
                prev = n;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("alt_acks", acks, 4);

        // READ_LAT=5 instance: m1 alone, then both masters back to back.
        @(negedge clock);
        l5_m1_req = 1'b1; l5_m1_address = 20'h00055;
        n = 0; acks = 0;
        while (acks < 3 && n < 60) begin
            @(negedge clock);
            n++;
            if (acks == 0 && n <= 5) begin
                chk("l5_addr_hold", l5_mem_address, 20'h00055);
                chk("l5_grant_m1", l5_grant, 2'b10);
            end
            if (l5_m0_ack === 1'b1 || l5_m1_ack === 1'b1) begin
                acks++;
                chk("l5_ack_time", n, 6 * acks);
                chk("l5_ack_master", {l5_m0_ack, l5_m1_ack}, (acks == 2) ? 2'b10 : 2'b01);
                chk("l5_rdata", (acks == 2) ? l5_m0_in : l5_m1_in, (acks == 2) ? 8'h2C : 8'h1F);
                $display("txn: l5 m%0d read ack at cycle %0d, data 0x%02h",
                         (acks == 2) ? 0 : 1, n, (acks == 2) ? l5_m0_in : l5_m1_in);
                if (acks == 1) begin
                    l5_m0_req = 1'b1; l5_m0_address = 20'h00066;
                end
            end
        end
        l5_m0_req = 1'b0;
        l5_m1_req = 1'b0;
        chk("l5_acks", acks, 3);

        repeat (4) @(negedge clock);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
